mem_port_arbiter: RTL and testbench

//  Shares the core's single unified memory port between instruction fetch (IF) and

---
 rtl/mem_port_arbiter_pkg.sv | 7 +
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings and default widths for the memory port arbiter
package mem_port_arbiter_pkg;
    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;
    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_e;
    typedef enum logic {OWN_IF, OWN_DM} owner_e;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and load/store (DM), DM first with IF starvation guard
// Ports:
//   clk, rst                      clock, async active-high reset
//   if_req/if_addr/if_flush       fetch request side; if_gnt/if_rvld/if_rdata responses
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata  load/store request side; dm_gnt/dm_rvld/dm_rdata responses
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  bus command, held until mem_ready
//   mem_ready/mem_rvld/mem_rdata  bus accept and read return
//   stall_if, stall_dm            per-requester hold for the hazard controller
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = MEM_AW,
    parameter int DW         = MEM_DW,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_flush,
    output logic            if_gnt,
    output logic            if_rvld,
    output logic [DW-1:0]   if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [DW/8-1:0] dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic            dm_gnt,
    output logic            dm_rvld,
    output logic [DW-1:0]   dm_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ready,
    input  logic            mem_rvld,
    input  logic [DW-1:0]   mem_rdata,
    output logic            stall_if,
    output logic            stall_dm
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    arb_state_e    state_q, state_d;
    owner_e        owner;
    logic          drop;
    logic [CW-1:0] starve_cnt;
    logic          hold, if_ok, pick_dm, st_done, rd_done, if_done, dm_done;
    // The requester that just got rvld still shows its old req this cycle, so no grant is made then
    assign hold     = rst | if_rvld | dm_rvld;
    assign if_ok    = if_req & ~if_flush;
    assign pick_dm  = dm_req & ((starve_cnt < CW'(STARVE_MAX)) | ~if_ok);
    assign mem_req  = state_q == ARB_REQ;
    assign st_done  = mem_req & mem_ready & mem_we;
    assign rd_done  = (state_q == ARB_WAIT) & mem_rvld;
    assign if_done  = rd_done & (owner == OWN_IF) & ~drop & ~if_flush;
    assign dm_done  = st_done | (rd_done & (owner == OWN_DM));
    assign stall_if = ~rst & if_req & ~if_rvld;
    assign stall_dm = ~rst & dm_req & ~dm_rvld;
    always_comb begin
        state_d = state_q;
        if_gnt  = 1'b0;
        dm_gnt  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                dm_gnt  = ~hold & pick_dm;
                if_gnt  = ~hold & ~pick_dm & if_ok;
                state_d = (dm_gnt | if_gnt) ? ARB_REQ : ARB_IDLE;
            end
            ARB_REQ:  state_d = mem_ready ? (mem_we ? ARB_IDLE : ARB_WAIT) : ARB_REQ;
            ARB_WAIT: state_d = mem_rvld ? ARB_IDLE : ARB_WAIT;
            default:  state_d = ARB_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ARB_IDLE;
        else     state_q <= state_d;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_IF;
            drop       <= 1'b0;
            starve_cnt <= '0;
            if_rvld    <= 1'b0;
            dm_rvld    <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            if_rvld <= if_done;
            dm_rvld <= dm_done;
            // A flushed fetch still finishes on the bus; only its response is swallowed
            drop    <= (state_d != ARB_IDLE) & (drop | ((state_q != ARB_IDLE) & (owner == OWN_IF) & if_flush));
            if (if_gnt | dm_gnt) begin
                owner     <= dm_gnt ? OWN_DM : OWN_IF;
                mem_we    <= dm_gnt & dm_we;
                mem_be    <= (dm_gnt & dm_we) ? dm_be : '1;
                mem_addr  <= dm_gnt ? dm_addr : if_addr;
                mem_wdata <= (dm_gnt & dm_we) ? dm_wdata : '0;
            end
            if (if_done) if_rdata <= mem_rdata;
            if (dm_done) dm_rdata <= st_done ? '0 : mem_rdata;
            starve_cnt <= if_gnt ? '0
                        : (dm_gnt & if_req & (starve_cnt < CW'(STARVE_MAX))) ? starve_cnt + 1'b1
                        : ((state_q == ARB_IDLE) & ~if_req) ? '0
                        : starve_cnt;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench for mem_port_arbiter with a simple bus responder
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst;
    logic        if_req, if_flush, if_gnt, if_rvld;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvld;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ready, mem_rvld;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_if, stall_dm;
    int n_cmp = 0, n_err = 0, cyc = 0;
    int ready_delay = 0, rvld_lag = 0;
    typedef struct packed {logic dm; logic [31:0] data;} exp_t;
    exp_t sb[$];

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvld(if_rvld), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvld(dm_rvld), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvld(mem_rvld), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_dm(stall_dm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_of(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic dm, input logic [31:0] d);
        sb.push_back(exp_t'{dm: dm, data: d});
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // which: 0 if_gnt, 1 dm_gnt, 2 if_rvld, 3 dm_rvld; returns at the negedge where it is seen
    task automatic wait_sig(input int which, input string tag);
        logic hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            hit = (which == 0) ? if_gnt : (which == 1) ? dm_gnt : (which == 2) ? if_rvld : dm_rvld;
            if (!hit) nxt();
        end
        chk(tag, hit, 1);
    endtask

    // Bus responder: ready after ready_delay cycles of mem_req, read data rvld_lag cycles after accept+1
    initial begin
        int hold_left = 0, pend_cnt = 0;
        logic pend = 1'b0;
        logic [31:0] pend_addr = '0;
        mem_ready = 1'b0;
        mem_rvld  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && mem_ready && !mem_we) begin
                pend      = 1'b1;
                pend_cnt  = rvld_lag;
                pend_addr = mem_addr;
            end
            @(posedge clk);
            #2;
            mem_rvld = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    mem_rvld  = 1'b1;
                    mem_rdata = mem_of(pend_addr);
                    pend      = 1'b0;
                end else pend_cnt--;
            end
            if (!mem_req) begin
                hold_left = ready_delay;
                mem_ready = 1'b0;
            end else if (hold_left > 0) begin
                hold_left--;
                mem_ready = 1'b0;
            end else mem_ready = 1'b1;
        end
    end

    // Response monitor: every rvld must match the oldest expected response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_rvld) begin
                chk("if_rvld_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("if_rvld_owner", e.dm, 0);
                    chk("if_rdata", if_rdata, e.data);
                end
            end
            if (dm_rvld) begin
                chk("dm_rvld_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("dm_rvld_owner", e.dm, 1);
                    chk("dm_rdata", dm_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        logic [6:0] seq;
        int ng;
        logic drop_if;
        rst = 1'b1;
        if_req = 0; if_addr = 0; if_flush = 0;
        dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
        @(negedge clk);
        chk("rst_ctrl", {if_gnt, if_rvld, dm_gnt, dm_rvld, mem_req, mem_we, mem_be, stall_if, stall_dm}, 0);
        chk("rst_bus", {mem_addr, mem_wdata}, 0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 0);
        nxt(); rst = 1'b0;
        nxt();
        // single zero-wait fetch
        if_req = 1; if_addr = 32'h100; push(0, 32'h13);
        @(negedge clk);
        chk("t1_if_gnt", if_gnt, 1);
        chk("t1_mem_req_n", mem_req, 0);
        chk("t1_stall_if", stall_if, 1);
        nxt(); @(negedge clk);
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_cmd", {mem_we, mem_be}, 5'h0F);
        chk("t1_no_gnt", if_gnt, 0);
        nxt(); @(negedge clk);
        chk("t1_rvld_early", if_rvld, 0);
        nxt(); @(negedge clk);
        chk("t1_if_rvld", if_rvld, 1);
        chk("t1_stall_off", stall_if, 0);
        chk("t1_no_regrant", if_gnt, 0);
        nxt(); if_req = 0;
        nxt();
        // simultaneous requests: DM first, IF at next IDLE
        if_req = 1; if_addr = 32'h104;
        dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
        push(1, mem_of(32'h2000)); push(0, mem_of(32'h104));
        @(negedge clk);
        chk("t2_dm_first", dm_gnt, 1);
        chk("t2_if_waits", if_gnt, 0);
        chk("t2_stall_dm", stall_dm, 1);
        g0 = cyc;
        nxt(); wait_sig(3, "t2_dm_rvld");
        nxt(); dm_req = 0;
        wait_sig(0, "t2_if_gnt");
        chk("t2_grant_gap", cyc - g0, 4);
        nxt(); wait_sig(2, "t2_if_rvld");
        nxt(); if_req = 0;
        nxt();
        // starvation guard: four DM stores, then IF, then DM again
        if_req = 1; if_addr = 32'h200;
        dm_req = 1; dm_we = 1; dm_be = 4'h3; dm_addr = 32'h3000; dm_wdata = 32'hCAFE_0001;
        repeat (4) push(1, 0);
        push(0, mem_of(32'h200));
        repeat (2) push(1, 0);
        seq = '0; ng = 0; drop_if = 0;
        for (int c = 0; c < 200 && ng < 7; c++) begin
            @(negedge clk);
            if (dm_gnt | if_gnt) begin
                seq[ng] = dm_gnt;
                ng++;
            end
            if (if_rvld) drop_if = 1;
            nxt();
            if (drop_if) if_req = 0;
        end
        chk("t3_grant_order", seq, 7'b110_1111);
        wait_sig(3, "t3_dm_rvld");
        nxt(); dm_req = 0; dm_we = 0;
        nxt();
        // flush while fetch is waiting for read data
        rvld_lag = 2; if_req = 1; if_addr = 32'h300;
        @(negedge clk);
        chk("t4_if_gnt", if_gnt, 1);
        nxt(); nxt(); if_flush = 1; if_req = 0;
        @(negedge clk);
        chk("t4_in_wait", mem_req, 0);
        nxt(); if_flush = 0;
        nxt(); @(negedge clk);
        chk("t4_no_rvld_a", if_rvld, 0);
        nxt(); dm_req = 1; dm_we = 0; dm_addr = 32'h2004; push(1, mem_of(32'h2004));
        @(negedge clk);
        chk("t4_idle_dm_gnt", dm_gnt, 1);
        chk("t4_no_rvld_b", if_rvld, 0);
        nxt(); wait_sig(3, "t4_dm_rvld");
        nxt(); dm_req = 0; rvld_lag = 0;
        nxt();
        // bus holds off ready for three cycles
        ready_delay = 3;
        dm_req = 1; dm_we = 1; dm_be = 4'hC; dm_addr = 32'h4000; dm_wdata = 32'h1234_5678;
        push(1, 0);
        @(negedge clk);
        chk("t5_dm_gnt", dm_gnt, 1);
        for (int i = 0; i < 3; i++) begin
            nxt(); @(negedge clk);
            chk("t5_addr", mem_addr, 32'h4000);
            chk("t5_wdata", mem_wdata, 32'h1234_5678);
            chk("t5_ctl", {mem_req, mem_we, mem_be}, 6'b11_1100);
        end
        nxt(); @(negedge clk);
        chk("t5_accept_req", mem_req, 1);
        nxt(); @(negedge clk);
        chk("t5_dm_rvld", dm_rvld, 1);
        nxt(); dm_req = 0; dm_we = 0; ready_delay = 0;
        nxt();
        // reset while waiting for read data; the late return must be ignored
        rvld_lag = 3; if_req = 1; if_addr = 32'h500;
        @(negedge clk);
        chk("t6_if_gnt", if_gnt, 1);
        nxt(); nxt(); rst = 1; if_req = 0;
        #1;
        chk("t6_rst_ctrl", {if_gnt, if_rvld, dm_gnt, dm_rvld, mem_req, mem_we, mem_be, stall_if, stall_dm}, 0);
        chk("t6_rst_bus", {mem_addr, mem_wdata}, 0);
        chk("t6_rst_rdata", {if_rdata, dm_rdata}, 0);
        nxt(); rst = 0; rvld_lag = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_late_rvld", {if_rvld, dm_rvld}, 0);
            nxt();
        end
        // normal operation after reset
        if_req = 1; if_addr = 32'h600; push(0, mem_of(32'h600));
        wait_sig(2, "t7_if_rvld");
        nxt(); if_req = 0;
        repeat (3) nxt();
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
